// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the three-digit BCD display controller.
package bcd_display_pkg;

   // Conversion sequencer states
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Number of double-dabble iterations for an 8-bit input
   localparam int ITER_COUNT = 8;

   // Active-high segment patterns, bit6=a ... bit0=g
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
   };
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // One-hot digit enables
   localparam logic [2:0] ANODE_UNITS    = 3'b001;
   localparam logic [2:0] ANODE_TENS     = 3'b010;
   localparam logic [2:0] ANODE_HUNDREDS = 3'b100;

   // Add 3 to a BCD nibble that is 5 or more; 4-bit result, carry-out dropped
   function automatic logic [3:0] add3_nibble(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

   // One double-dabble step on the BCD scratch: correct nibbles, shift left,
   // bring in the next binary bit at the bottom
   function automatic logic [11:0] dabble_step(input logic [11:0] s, input logic b);
      logic [11:0] a;
      a = {add3_nibble(s[11:8]), add3_nibble(s[7:4]), add3_nibble(s[3:0])};
      return {a[10:0], b};
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-high 7-segment decoder with a blanking override.
module bcd_to_seg7
   import bcd_display_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   // Decode the digit; blank or non-decimal codes switch all segments off
   always_comb begin
      seg = SEG_BLANK;
      if (blank) begin
         seg = SEG_BLANK;
      end else begin
         case (digit)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/bcd_display_scan_ctrl.sv
// Binary-to-BCD conversion sequencer and three-digit multiplexed display scanner.
module bcd_display_scan_ctrl
   import bcd_display_pkg::*;
#(
   parameter int SCAN_DIV      = 4,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        In_Valid,
   output logic        In_Ready,
   input  logic [7:0]  Decimal,
   output logic        Busy,
   output logic        Done,
   output logic [11:0] BCD,
   output logic [6:0]  Segments,
   output logic [2:0]  Anode
);

   localparam int             PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [2:0]     CNT_LAST   = 3'(ITER_COUNT - 1);

   state_t        state_r;
   state_t        state_next_s;
   logic [7:0]    bin_r;
   logic [11:0]   scratch_r;
   logic [2:0]    cnt_r;
   logic [11:0]   bcd_r;
   logic          done_r;
   logic          accept_s;
   logic          last_iter_s;
   logic [11:0]   scratch_next_s;

   logic [PW-1:0] presc_r;
   logic [1:0]    idx_r;
   logic [1:0]    idx_next_s;
   logic [3:0]    digit_s;
   logic          blank_s;
   logic [2:0]    anode_s;
   logic [6:0]    seg_s;
   logic [6:0]    seg_r;
   logic [2:0]    anode_r;

   assign accept_s       = In_Valid && (state_r == IDLE);
   assign last_iter_s    = (state_r == SHIFT) && (cnt_r == CNT_LAST);
   assign scratch_next_s = dabble_step(scratch_r, bin_r[7]);

   // Next-state logic: leave IDLE on a handshake, return after the last iteration
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_next_s = SHIFT;
            end else begin
               state_next_s = IDLE;
            end
         end
         SHIFT: begin
            if (last_iter_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = SHIFT;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Double-dabble datapath; the committed value only changes on the final iteration
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bin_r     <= 8'd0;
         scratch_r <= 12'd0;
         cnt_r     <= 3'd0;
         bcd_r     <= 12'd0;
         done_r    <= 1'b0;
      end else begin
         done_r <= last_iter_s;
         if (accept_s) begin
            bin_r     <= Decimal;
            scratch_r <= 12'd0;
            cnt_r     <= 3'd0;
         end else if (state_r == SHIFT) begin
            bin_r     <= {bin_r[6:0], 1'b0};
            scratch_r <= scratch_next_s;
            cnt_r     <= cnt_r + 3'd1;
            if (last_iter_s) begin
               bcd_r <= scratch_next_s;
            end
         end
      end
   end

   // Scan index for the coming cycle and the digit/enable it selects
   always_comb begin
      idx_next_s = idx_r;
      if (presc_r == PRESC_LAST) begin
         idx_next_s = (idx_r == 2'd2) ? 2'd0 : (idx_r + 2'd1);
      end else begin
         idx_next_s = idx_r;
      end
      digit_s = bcd_r[3:0];
      blank_s = 1'b0;
      anode_s = ANODE_UNITS;
      case (idx_next_s)
         2'd0: begin
            digit_s = bcd_r[3:0];
            blank_s = 1'b0;
            anode_s = ANODE_UNITS;
         end
         2'd1: begin
            digit_s = bcd_r[7:4];
            blank_s = BLANK_LEADING && (bcd_r[11:8] == 4'd0) && (bcd_r[7:4] == 4'd0);
            anode_s = ANODE_TENS;
         end
         2'd2: begin
            digit_s = bcd_r[11:8];
            blank_s = BLANK_LEADING && (bcd_r[11:8] == 4'd0);
            anode_s = ANODE_HUNDREDS;
         end
         default: begin
            digit_s = bcd_r[3:0];
            blank_s = 1'b0;
            anode_s = ANODE_UNITS;
         end
      endcase
   end

   bcd_to_seg7 u_seg_dec (
      .digit (digit_s),
      .blank (blank_s),
      .seg   (seg_s)
   );

   // Scanner prescaler, index and registered display pins updated together
   always_ff @(posedge Clk) begin
      if (Reset) begin
         presc_r <= '0;
         idx_r   <= 2'd0;
         anode_r <= ANODE_UNITS;
         seg_r   <= SEG_DIGIT[0];
      end else begin
         presc_r <= (presc_r == PRESC_LAST) ? '0 : (presc_r + PW'(1));
         idx_r   <= idx_next_s;
         anode_r <= anode_s;
         seg_r   <= seg_s;
      end
   end

   assign In_Ready = (state_r == IDLE);
   assign Busy     = (state_r != IDLE);
   assign Done     = done_r;
   assign BCD      = bcd_r;
   assign Segments = seg_r;
   assign Anode    = anode_r;

endmodule
